// File: rtl/arb_pkg.sv
// Shared types and helpers for the multi-grant fixed-priority arbiter.
// Optional hold limit in the arbiter top is enabled with the ARB_HOLD_LIMIT_EN macro.
package arb_pkg;

    localparam int MAX_VEC         = 64;
    localparam int CNT_MAX_W       = $clog2(MAX_VEC + 1);
    localparam int DEFAULT_NUM_REQ = 8;

    typedef logic [DEFAULT_NUM_REQ-1:0] req_vec_t;

    // Callers zero-extend into MAX_VEC bits and cast the result down to their count width.
    function automatic logic [CNT_MAX_W-1:0] popcount(input logic [MAX_VEC-1:0] v);
        logic [CNT_MAX_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_VEC; i++) begin
            c = c + CNT_MAX_W'(v[i]);
        end
        return c;
    endfunction

    function automatic bit params_ok(input int num_req, input int num_gnt, input int max_hold);
        return (num_req >= 2) && (num_req <= MAX_VEC) &&
               (num_gnt >= 1) && (num_gnt <= num_req) && (max_hold >= 1);
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter_multi_grant_prio_select_k.sv
// Combinational selector: passes the lowest-index min(k, popcount(vec)) set bits of vec.
module prio_select_k #(
    parameter int N     = 8,
    parameter int K_MAX = 2
) (
    input  logic [N-1:0]                 vec,
    input  logic [$clog2(K_MAX+1)-1:0]   k,
    output logic [N-1:0]                 sel
);

    localparam int KW = $clog2(K_MAX + 1);

    logic [KW-1:0] remaining;

    always_comb begin
        sel       = '0;
        remaining = k;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && (remaining != '0)) begin
                sel[i]    = 1'b1;
                remaining = remaining - KW'(1);
            end
        end
    end

endmodule

// File: rtl/fixed_priority_arbiter_multi_grant.sv
// N-requester, M-grant fixed-priority arbiter with sticky grants (bit 0 highest priority).
// Define ARB_HOLD_LIMIT_EN to force a grant to drop after MAX_HOLD consecutive cycles.
module fixed_priority_arbiter_multi_grant
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int NUM_GNT  = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(NUM_GNT+1)-1:0] grant_cnt,
    output logic                         full
);

    localparam int CNT_W = $clog2(NUM_GNT + 1);

    generate
        if (!params_ok(NUM_REQ, NUM_GNT, MAX_HOLD)) begin : g_param_check
            $fatal(1, "fixed_priority_arbiter_multi_grant: illegal NUM_REQ/NUM_GNT/MAX_HOLD");
        end
    endgenerate

    logic [NUM_REQ-1:0] expire;
    logic [NUM_REQ-1:0] keep;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] add;
    logic [NUM_REQ-1:0] grant_next;
    logic [CNT_W-1:0]   keep_cnt;
    logic [CNT_W-1:0]   slots;
    logic [CNT_W-1:0]   next_cnt;

    // Existing holders keep their slot; only the slots left over go to waiting requesters.
    assign keep     = grant & req & ~expire;
    assign elig     = req & ~grant;
    assign keep_cnt = CNT_W'(popcount(MAX_VEC'(keep)));
    assign slots    = CNT_W'(NUM_GNT) - keep_cnt;

    prio_select_k #(
        .N     (NUM_REQ),
        .K_MAX (NUM_GNT)
    ) u_select (
        .vec (elig),
        .k   (slots),
        .sel (add)
    );

    assign grant_next = keep | add;
    assign next_cnt   = CNT_W'(popcount(MAX_VEC'(grant_next)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            grant_cnt <= '0;
            full      <= 1'b0;
        end else begin
            grant     <= grant_next;
            grant_cnt <= next_cnt;
            full      <= (next_cnt == CNT_W'(NUM_GNT));
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt [NUM_REQ];

    // Counter reads 0 during the first granted cycle, so expiry hits after exactly MAX_HOLD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && grant_next[i]) begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                end else begin
                    hold_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            expire[i] = grant[i] && (hold_cnt[i] == HOLD_W'(MAX_HOLD - 1));
        end
    end
`else
    assign expire = '0;
`endif

endmodule
